// File: rtl/hptw_sv39.sv
// Sv39 hardware page-table walker.
// On a TLB miss it reads up to three PTEs through one request/response port,
// then either fills the TLB with the leaf PTE or reports a page/access fault.
// Translation stays disabled in every state except IDLE, so walker addresses
// pass through the MMU as physical addresses.
module hptw_sv39 #(
    parameter int XLEN    = 64,
    parameter int PA_BITS = 56
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    SATP_REGW,
    input  logic               TLBMiss,
    input  logic [XLEN-1:0]    VAdr,
    input  logic               TLBFlush,
    output logic               HPTWReq,
    output logic [PA_BITS-1:0] HPTWAdr,
    input  logic               HPTWReady,
    input  logic               HPTWRespValid,
    input  logic [XLEN-1:0]    HPTWReadPTE,
    input  logic               HPTWRespAccessFault,
    output logic [XLEN-1:0]    PTE,
    output logic [1:0]         PageTypeWriteVal,
    output logic               TLBWrite,
    output logic               DisableTranslation,
    output logic               WalkerPageFault,
    output logic               WalkerAccessFault
);

    // PPN (44) + VPN slice (9) + byte offset of an 8-byte PTE (3)
    localparam int FULL_ADR_W = 56;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FILL  = 3'd3,
        FAULT = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        level_q, level_d;
    logic [43:0]       ppn_q, ppn_d;
    logic [XLEN-1:0]   pte_q, pte_d;
    logic [1:0]        ptype_q, ptype_d;
    logic              acc_fault_q, acc_fault_d;

    logic [8:0]            vpn;
    logic [FULL_ADR_W-1:0] full_adr;
    logic                  pte_v, pte_r, pte_w, pte_x;
    logic                  pte_leaf, pte_invalid, pte_misaligned;

    // Bits of the inputs the walker never looks at.
    logic unused_bits;
    assign unused_bits = ^{SATP_REGW[XLEN-1:44], VAdr[XLEN-1:39], VAdr[11:0]};

    // Select the VPN slice for the current level and form the PTE address.
    always_comb begin
        vpn = VAdr[20:12];
        case (level_q)
            2'd2:    vpn = VAdr[38:30];
            2'd1:    vpn = VAdr[29:21];
            default: vpn = VAdr[20:12];
        endcase
        full_adr = {ppn_q, vpn, 3'b000};
    end

    // Decode the returned PTE: validity, leaf-ness and superpage alignment.
    always_comb begin
        pte_v          = HPTWReadPTE[0];
        pte_r          = HPTWReadPTE[1];
        pte_w          = HPTWReadPTE[2];
        pte_x          = HPTWReadPTE[3];
        pte_leaf       = pte_r | pte_x;
        // W without R is a reserved encoding and faults like V=0.
        pte_invalid    = ~pte_v | (~pte_r & pte_w);
        pte_misaligned = ((level_q == 2'd2) && (HPTWReadPTE[27:10] != 18'd0)) ||
                         ((level_q == 2'd1) && (HPTWReadPTE[18:10] != 9'd0));
    end

    // Next-state logic for the walk FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        ppn_d       = ppn_q;
        pte_d       = pte_q;
        ptype_d     = ptype_q;
        acc_fault_d = acc_fault_q;
        case (state_q)
            IDLE: begin
                if (TLBMiss && !TLBFlush) begin
                    state_d = REQ;
                    level_d = 2'd2;
                    ppn_d   = SATP_REGW[43:0];
                end
            end
            REQ: begin
                if (TLBFlush) begin
                    state_d = IDLE;
                end else if (HPTWReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (TLBFlush) begin
                    // A response arriving with the flush is simply dropped;
                    // otherwise it is still in flight and must be absorbed.
                    state_d = HPTWRespValid ? IDLE : DRAIN;
                end else if (HPTWRespValid) begin
                    if (HPTWRespAccessFault) begin
                        state_d     = FAULT;
                        acc_fault_d = 1'b1;
                    end else if (pte_invalid) begin
                        state_d     = FAULT;
                        acc_fault_d = 1'b0;
                    end else if (!pte_leaf) begin
                        if (level_q == 2'd0) begin
                            state_d     = FAULT;
                            acc_fault_d = 1'b0;
                        end else begin
                            ppn_d   = HPTWReadPTE[53:10];
                            level_d = level_q - 2'd1;
                            state_d = REQ;
                        end
                    end else if (pte_misaligned) begin
                        state_d     = FAULT;
                        acc_fault_d = 1'b0;
                    end else begin
                        pte_d   = HPTWReadPTE;
                        ptype_d = level_q;
                        state_d = FILL;
                    end
                end
            end
            FILL:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            DRAIN: begin
                if (HPTWRespValid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            level_q     <= 2'd2;
            ppn_q       <= '0;
            pte_q       <= '0;
            ptype_q     <= 2'd0;
            acc_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            ppn_q       <= ppn_d;
            pte_q       <= pte_d;
            ptype_q     <= ptype_d;
            acc_fault_q <= acc_fault_d;
        end
    end

    // Outputs are decoded from the registered state; a flush in REQ withholds
    // the request so memory never accepts a walk that is being abandoned.
    always_comb begin
        HPTWReq            = (state_q == REQ) && !TLBFlush;
        HPTWAdr            = (state_q != IDLE) ? full_adr[PA_BITS-1:0] : '0;
        PTE                = pte_q;
        PageTypeWriteVal   = ptype_q;
        TLBWrite           = (state_q == FILL) && !TLBFlush;
        DisableTranslation = (state_q != IDLE);
        WalkerPageFault    = (state_q == FAULT) && !acc_fault_q;
        WalkerAccessFault  = (state_q == FAULT) && acc_fault_q;
    end

endmodule
